plab4_net_domain_chan_buf: RTL and testbench

Buffered, parametrised inter-router ring channel that replaces the two-way combinational domain demux between adjacent ring routers. It accepts one split control/data message stream tagged with a security domain and steers each message into a dedicated per-domain queue. Each queue drives its own output channel into the downstream router. Queue occupancy is exported as per-domain free-slot counts for adaptive routing. Back-pressure on any domain is isolated from every other domain.

---
 rtl/plab4_net_domain_chan_buf_pkg.sv | 21 ++
 rtl/plab4_net_domain_chan_buf_queue.sv | 60 ++++++
 rtl/plab4_net_domain_chan_buf.sv | 96 +++++++++
 tb/tb_plab4_net_domain_chan_buf.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plab4_net_domain_chan_buf_pkg.sv
// Shared sizing helpers for the per-domain buffered ring channel.
// net_msg_nbits mirrors the shared net message layout: dest, src, opaque, payload.
// free_nbits is the width routers use for their num_free inputs.
package plab4_net_domain_chan_buf_pkg;

  // Width of a packed net control message.
  function automatic int net_msg_nbits(input int payload, input int opaque, input int srcdest);
    return payload + opaque + 2 * srcdest;
  endfunction

  // Width of a free-entry count for a queue of the given depth.
  function automatic int free_nbits(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; a single-entry queue still gets a 1-bit pointer.
  function automatic int ptr_nbits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/plab4_net_domain_chan_buf_queue.sv
// plab4_net_DomainQueue: circular FIFO holding one domain's control+data messages.
// Full/empty come from an occupancy counter, so no pointer-equality ambiguity.
module plab4_net_DomainQueue
  import plab4_net_domain_chan_buf_pkg::*;
#(
  parameter int p_width = 73,
  parameter int p_depth = 2,
  localparam int fw = free_nbits(p_depth),
  localparam int pw = ptr_nbits(p_depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_width-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_width-1:0] deq_msg,
  output logic [fw-1:0]      count
);

  logic [pw-1:0]      head;
  logic [pw-1:0]      tail;
  logic [fw-1:0]      cnt;
  logic [p_width-1:0] mem [p_depth];
  logic               full;
  logic               empty;
  logic               do_enq;
  logic               do_deq;

  assign full    = (cnt == fw'(p_depth));
  assign empty   = (cnt == '0);
  assign enq_rdy = !full;
  assign deq_val = !empty;
  assign deq_msg = mem[head];
  assign count   = cnt;
  // Enqueue is refused when full even if a dequeue happens the same cycle.
  assign do_enq  = enq_val && !full;
  assign do_deq  = deq_rdy && !empty;

  // Pointer and occupancy state; reset flushes the queue immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_enq) tail <= (tail == pw'(p_depth - 1)) ? '0 : tail + pw'(1);
      if (do_deq) head <= (head == pw'(p_depth - 1)) ? '0 : head + pw'(1);
      if (do_enq && !do_deq) cnt <= cnt + fw'(1);
      else if (!do_enq && do_deq) cnt <= cnt - fw'(1);
    end
  end

  // Storage write; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (do_enq) mem[tail] <= enq_msg;
  end

endmodule

// File: rtl/plab4_net_domain_chan_buf.sv
// plab4_net_domain_chan_buf: steers a domain-tagged message stream into one queue per
// security domain; each queue drives its own output channel and free-slot count.
// Optional macro PLAB4_NET_CHAN_BYPASS_EN: an empty queue forwards the incoming message
// combinationally (0-cycle latency); otherwise all outputs come from registered state.
module plab4_net_domain_chan_buf
  import plab4_net_domain_chan_buf_pkg::*;
#(
  parameter int p_payload_cnbits = 32,
  parameter int p_payload_dnbits = 32,
  parameter int p_opaque_nbits   = 3,
  parameter int p_srcdest_nbits  = 3,
  parameter int p_num_domains    = 2,
  parameter int p_depth          = 2,
  localparam int m  = net_msg_nbits(p_payload_cnbits, p_opaque_nbits, p_srcdest_nbits),
  localparam int pd = p_payload_dnbits,
  localparam int dw = $clog2(p_num_domains),
  localparam int fw = free_nbits(p_depth)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [dw-1:0]               in_domain,
  input  logic [m-1:0]                in_msg_control,
  input  logic [pd-1:0]               in_msg_data,
  output logic [p_num_domains-1:0]    out_val,
  input  logic [p_num_domains-1:0]    out_rdy,
  output logic [p_num_domains*m-1:0]  out_msg_control,
  output logic [p_num_domains*pd-1:0] out_msg_data,
  output logic [p_num_domains*fw-1:0] out_num_free
);

  localparam int w      = m + pd;
  localparam int nslots = 2 ** dw;

  logic [p_num_domains-1:0] sel;
  logic [p_num_domains-1:0] byp;
  logic [p_num_domains-1:0] q_enq;
  logic [p_num_domains-1:0] q_enq_rdy;
  logic [p_num_domains-1:0] q_val;
  logic [w-1:0]             q_head  [p_num_domains];
  logic [fw-1:0]            q_count [p_num_domains];
  logic [nslots-1:0]        rdy_slot;
  logic [w-1:0]             in_msg;

  assign in_msg = {in_msg_control, in_msg_data};

  // Ready per tag value; tags beyond the last domain always accept and are dropped.
  always_comb begin
    rdy_slot = '1;
    for (int d = 0; d < p_num_domains; d++) rdy_slot[d] = q_enq_rdy[d];
  end

  assign in_rdy = rdy_slot[in_domain];

  for (genvar d = 0; d < p_num_domains; d++) begin : g_dom
    logic [w-1:0] view;

    assign sel[d] = in_val && (in_domain == dw'(d));
`ifdef PLAB4_NET_CHAN_BYPASS_EN
    assign byp[d] = sel[d] && !q_val[d];
`else
    assign byp[d] = 1'b0;
`endif
    // A bypassed message taken downstream this cycle is never written.
    assign q_enq[d] = sel[d] && !(byp[d] && out_rdy[d]);

    plab4_net_DomainQueue #(
      .p_width (w),
      .p_depth (p_depth)
    ) u_queue (
      .clk     (clk),
      .reset   (reset),
      .enq_val (q_enq[d]),
      .enq_rdy (q_enq_rdy[d]),
      .enq_msg (in_msg),
      .deq_val (q_val[d]),
      .deq_rdy (out_rdy[d]),
      .deq_msg (q_head[d]),
      .count   (q_count[d])
    );

    // Output view: queue head, bypassed input, or zero so stale data never shows.
    always_comb begin
      view = '0;
      if (q_val[d]) view = q_head[d];
      else if (byp[d]) view = in_msg;
    end

    assign out_val[d]                  = q_val[d] | byp[d];
    assign out_msg_control[d*m +: m]   = view[w-1 -: m];
    assign out_msg_data[d*pd +: pd]    = view[pd-1:0];
    assign out_num_free[d*fw +: fw]    = fw'(p_depth) - q_count[d];
  end

endmodule

// File: tb/tb_plab4_net_domain_chan_buf.sv
// Bench for plab4_net_domain_chan_buf: instance a (D=2, depth=2) and instance b
// (D=3, depth=3) run against a queue-based model, checked every negedge, plus
// literal expectations for the directed scenarios.
module tb_plab4_net_domain_chan_buf;

  localparam int M  = 41;
  localparam int PD = 32;
  localparam int W  = M + PD;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_val  [2];
  logic [1:0]    in_dom  [2];
  logic [M-1:0]  in_ctl  [2];
  logic [PD-1:0] in_dat  [2];
  logic [2:0]    out_rdy [2];

  logic          in_rdy_a, in_rdy_b;
  logic [1:0]    out_val_a;
  logic [2:0]    out_val_b;
  logic [2*M-1:0]  out_ctl_a;
  logic [3*M-1:0]  out_ctl_b;
  logic [2*PD-1:0] out_dat_a;
  logic [3*PD-1:0] out_dat_b;
  logic [3:0]    free_a;
  logic [5:0]    free_b;

  plab4_net_domain_chan_buf u_dut_a (
    .clk             (clk),
    .reset           (reset),
    .in_val          (in_val[0]),
    .in_rdy          (in_rdy_a),
    .in_domain       (in_dom[0][0:0]),
    .in_msg_control  (in_ctl[0]),
    .in_msg_data     (in_dat[0]),
    .out_val         (out_val_a),
    .out_rdy         (out_rdy[0][1:0]),
    .out_msg_control (out_ctl_a),
    .out_msg_data    (out_dat_a),
    .out_num_free    (free_a)
  );

  plab4_net_domain_chan_buf #(
    .p_num_domains (3),
    .p_depth       (3)
  ) u_dut_b (
    .clk             (clk),
    .reset           (reset),
    .in_val          (in_val[1]),
    .in_rdy          (in_rdy_b),
    .in_domain       (in_dom[1]),
    .in_msg_control  (in_ctl[1]),
    .in_msg_data     (in_dat[1]),
    .out_val         (out_val_b),
    .out_rdy         (out_rdy[1]),
    .out_msg_control (out_ctl_b),
    .out_msg_data    (out_dat_b),
    .out_num_free    (free_b)
  );

  // Uniform per-instance view of DUT outputs.
  logic          o_rdy  [2];
  logic [2:0]    o_val  [2];
  logic [M-1:0]  o_ctl  [2][3];
  logic [PD-1:0] o_dat  [2][3];
  logic [1:0]    o_free [2][3];

  always_comb begin
    o_rdy[0] = in_rdy_a;
    o_rdy[1] = in_rdy_b;
    o_val[0] = {1'b0, out_val_a};
    o_val[1] = out_val_b;
    o_ctl[0][0] = out_ctl_a[M-1:0];
    o_ctl[0][1] = out_ctl_a[2*M-1:M];
    o_ctl[0][2] = '0;
    o_dat[0][0] = out_dat_a[PD-1:0];
    o_dat[0][1] = out_dat_a[2*PD-1:PD];
    o_dat[0][2] = '0;
    o_free[0][0] = free_a[1:0];
    o_free[0][1] = free_a[3:2];
    o_free[0][2] = '0;
    for (int d = 0; d < 3; d++) begin
      o_ctl[1][d]  = out_ctl_b[d*M +: M];
      o_dat[1][d]  = out_dat_b[d*PD +: PD];
      o_free[1][d] = free_b[d*2 +: 2];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int i, input logic [63:0] act,
                     input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s inst%0d: got %0h want %0h (t=%0t)", nm, i, act, want, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Instance i has i+2 domains and i+2 entries per domain queue.
  logic [W-1:0]  mq [2][3][$];
  logic [PD-1:0] rx [$];

  function automatic int nd(input int i);
    return i + 2;
  endfunction

  function automatic logic mrdy(input int i, input int dom);
    return (dom >= nd(i)) || (mq[i][dom].size() < nd(i));
  endfunction

  function automatic logic mbyp(input int i, input int d);
`ifdef PLAB4_NET_CHAN_BYPASS_EN
    return in_val[i] && (int'(in_dom[i]) == d) && (mq[i][d].size() == 0);
`else
    return (i < 0) && (d < 0);
`endif
  endfunction

  initial forever begin
    int       dom;
    logic     acc;
    logic     consumed;
    logic [W-1:0] pop;
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int i = 0; i < 2; i++)
        for (int d = 0; d < 3; d++) mq[i][d].delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        dom      = int'(in_dom[i]);
        acc      = in_val[i] && mrdy(i, dom);
        consumed = 1'b0;
        for (int d = 0; d < nd(i); d++) begin
          if (out_rdy[i][d]) begin
            if (mq[i][d].size() > 0) begin
              pop = mq[i][d].pop_front();
              if (i == 1) rx.push_back(pop[PD-1:0]);
            end else if (mbyp(i, d)) begin
              consumed = 1'b1;
              if (i == 1) rx.push_back(in_dat[i]);
            end
          end
        end
        if (acc && dom < nd(i) && !consumed) mq[i][dom].push_back({in_ctl[i], in_dat[i]});
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial forever begin
    logic [W-1:0] want;
    logic         v;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("in_rdy", i, 64'(o_rdy[i]), 64'(mrdy(i, int'(in_dom[i]))));
      for (int d = 0; d < nd(i); d++) begin
        want = '0;
        if (mq[i][d].size() > 0) want = mq[i][d][0];
        else if (mbyp(i, d)) want = {in_ctl[i], in_dat[i]};
        v = (mq[i][d].size() > 0) || mbyp(i, d);
        chk("out_val", i, 64'(o_val[i][d]), 64'(v));
        chk("out_ctl", i, 64'(o_ctl[i][d]), 64'(want[W-1:PD]));
        chk("out_dat", i, 64'(o_dat[i][d]), 64'(want[PD-1:0]));
        chk("num_free", i, 64'(o_free[i][d]), 64'(nd(i) - mq[i][d].size()));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input int i, input logic v, input int dom, input logic [M-1:0] c,
                     input logic [PD-1:0] dt);
    in_val[i] = v;
    in_dom[i] = 2'(dom);
    in_ctl[i] = c;
    in_dat[i] = dt;
  endtask

  initial begin
    int   sent;
    logic acc;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      put(i, 1'b0, 0, '0, '0);
      out_rdy[i] = 3'b000;
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_in_rdy", 0, 64'(in_rdy_a), 64'd1);
    chk("rst_out_val", 0, 64'(out_val_a), 64'd0);
    chk("rst_free_a", 0, 64'(free_a), 64'hA);
    chk("rst_ctl_zero", 0, 64'(|out_ctl_a), 64'd0);
    chk("rst_free_b", 1, 64'(free_b), 64'h3F);

    // Single message to domain 1.
    put(0, 1'b1, 1, 41'h5A, 32'hDEADBEEF);
    step();
    put(0, 1'b0, 0, '0, '0);
    #1;
    chk("t1_out_val", 0, 64'(out_val_a), 64'h2);
    chk("t1_ctl", 0, 64'(out_ctl_a[2*M-1:M]), 64'h5A);
    chk("t1_dat", 0, 64'(out_dat_a[2*PD-1:PD]), 64'hDEADBEEF);
    chk("t1_free1", 0, 64'(free_a[3:2]), 64'd1);
    chk("t1_ctl0_zero", 0, 64'(out_ctl_a[M-1:0]), 64'd0);
    out_rdy[0] = 3'b010;
    step();

    // Domain isolation: domain 0 blocked, domain 1 keeps flowing.
    for (int k = 1; k <= 3; k++) begin
      put(0, 1'b1, 0, 41'(k), 32'(k));
      #1;
      if (k == 3) chk("t2_in_rdy_full", 0, 64'(in_rdy_a), 64'd0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      put(0, 1'b1, 1, 41'(16 + k), 32'(16 + k));
      #1;
      chk("t2_in_rdy_d1", 0, 64'(in_rdy_a), 64'd1);
      step();
    end
    put(0, 1'b0, 0, '0, '0);
    out_rdy[0] = 3'b011;
    repeat (3) step();

    // Same-cycle enqueue/dequeue at count 1.
    out_rdy[0] = 3'b000;
    put(0, 1'b1, 0, 41'h20, 32'h20);
    step();
    out_rdy[0] = 3'b001;
    for (int k = 1; k <= 8; k++) begin
      put(0, 1'b1, 0, 41'(32 + k), 32'(32 + k));
      #1;
      chk("t3_free0", 0, 64'(free_a[1:0]), 64'd1);
      step();
    end
    put(0, 1'b0, 0, '0, '0);
    repeat (2) step();
    out_rdy[0] = 3'b000;

    // Pointer wrap on depth 3 with random downstream ready.
    sent = 0;
    for (int cyc = 0; cyc < 300 && sent < 10; cyc++) begin
      put(1, 1'b1, 1, 41'(sent + 100), 32'(sent));
      out_rdy[1] = {1'b0, 1'($urandom_range(0, 1)), 1'b0};
      #1;
      acc = mrdy(1, 1);
      step();
      if (acc) sent++;
    end
    put(1, 1'b0, 0, '0, '0);
    out_rdy[1] = 3'b111;
    repeat (5) step();
    chk("t4_sent", 1, 64'(sent), 64'd10);
    chk("t4_rx_cnt", 1, 64'(rx.size()), 64'd10);
    for (int k = 0; k < 10 && k < rx.size(); k++) chk("t4_rx_order", 1, 64'(rx[k]), 64'(k));

    // Out-of-range domain on D=3 is accepted and dropped.
    put(1, 1'b1, 3, 41'h77, 32'h77);
    #1;
    chk("t5_in_rdy", 1, 64'(in_rdy_b), 64'd1);
    step();
    put(1, 1'b0, 0, '0, '0);
    #1;
    chk("t5_out_val", 1, 64'(out_val_b), 64'd0);
    chk("t5_free", 1, 64'(free_b), 64'h3F);

    // Asynchronous reset with two queued messages.
    out_rdy[0] = 3'b000;
    put(0, 1'b1, 0, 41'h41, 32'h41);
    step();
    put(0, 1'b1, 0, 41'h42, 32'h42);
    step();
    put(0, 1'b0, 0, '0, '0);
    #1;
    chk("t6_pre_val", 0, 64'(out_val_a), 64'h1);
    chk("t6_pre_free", 0, 64'(free_a), 64'h8);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t6_val_cleared", 0, 64'(out_val_a), 64'd0);
    chk("t6_free_full", 0, 64'(free_a), 64'hA);
    step();
    reset = 1'b0;
    step();

`ifdef PLAB4_NET_CHAN_BYPASS_EN
    put(0, 1'b1, 0, 41'h55, 32'h55);
    #1;
    chk("byp_same_cycle", 0, 64'(out_val_a), 64'h1);
    chk("byp_dat", 0, 64'(out_dat_a[PD-1:0]), 64'h55);
    step();
    put(0, 1'b0, 0, '0, '0);
    out_rdy[0] = 3'b011;
    repeat (2) step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
